dma_target_emulator: RTL
========================

Name: dma_target_emulator

Overview:
Synthesisable bus-target and peripheral emulator for DMA verification of the SDMAC core. It grants the bus, terminates master cycles after a programmable number of wait states, and checks write data against a predicted pattern. It also models the WD33C93A-side DREQ/DACK handshake with incrementing byte data. It replaces ad-hoc per-testbench always-blocks with one parametrised block that can also be instantiated on the FPGA for loopback testing.

Parameters:
WAIT_STATES, 4, clocks from AS_n low to termination asserted (1..15)
TERM_MODE, 0, 0 = STERM_n (32-bit synchronous), 1 = DSACK_n=2'b00 (32-bit), 2 = DSACK_n=2'b01 (16-bit)
ADDR_STEP, 4, address increment per completed cycle
DATA_STEP, 32'h11000000, data increment per completed cycle
PD_SEED, 8'hAA, first peripheral byte after reset
MAX_XFER_W, 16, width of transfer counter

Ports:
SCLK  in  1  system clock (CPUCLKB)
RST  in  1  synchronous reset, active-high
AS_n  in  1  address strobe from master
DS_n  in  1  data strobe from master
R_W  in  1  1 = master read, 0 = master write
DATA_IN  in  32  data driven by master
DATA_OUT  out  32  read data to master
DATA_OE  out  1  DATA_OUT drive enable
STERM_n  out  1  synchronous termination
DSACK_n  out  2  asynchronous termination
BR_n  in  1  bus request
BGACK_n  in  1  bus grant acknowledge
BG_n  out  1  bus grant
DMA_GO  in  1  enables peripheral DREQ generation
XFER_LEN  in  MAX_XFER_W  byte transfers to request; 0 = unlimited
DACK_n  in  1  DMA acknowledge
IOR_n  in  1  peripheral read strobe
IOW_n  in  1  peripheral write strobe
DREQ_n  out  1  peripheral DMA request
PD_OUT  out  8  peripheral data
PD_OE  out  1  PD_OUT drive enable (= ~IOR_n)
XFER_CNT  out  MAX_XFER_W  completed peripheral transfers
CYC_CNT  out  16  completed bus cycles
MISMATCH  out  1  sticky write-data miscompare
DONE  out  1  XFER_LEN reached

Behaviour:
- Reset values: BG_n=1, STERM_n=1, DSACK_n=2'b11, DATA_OE=0, DATA_OUT=0, DREQ_n=1, PD_OUT=PD_SEED, XFER_CNT=0, CYC_CNT=0, MISMATCH=0, DONE=0.
- Reset taken mid-cycle aborts everything: terminations and grant deassert on the next edge.
- Arbiter states ARB_IDLE, ARB_GRANT, ARB_OWNED.
  - ARB_IDLE -> ARB_GRANT when BR_n=0, BGACK_n=1 and AS_n=1; BG_n=0.
  - ARB_GRANT -> ARB_OWNED when BGACK_n=0; BG_n=1.
  - ARB_OWNED -> ARB_IDLE when BGACK_n=1.
- Cycle states CYC_IDLE, CYC_WAIT, CYC_TERM, CYC_END; active only in ARB_OWNED.
  - CYC_IDLE -> CYC_WAIT on AS_n=0; wait counter loads WAIT_STATES-1.
  - CYC_WAIT decrements the counter; at 0 -> CYC_TERM and asserts termination per TERM_MODE.
  - CYC_TERM holds termination until AS_n=1 -> CYC_END.
  - CYC_END deasserts termination, adds ADDR_STEP to the address and DATA_STEP to the expected data (32-bit wrap), increments CYC_CNT (16-bit wrap), returns to CYC_IDLE.
  - STERM_n asserts for exactly 1 clock; DSACK_n holds until AS_n high.
- Read cycles: DATA_OUT = current data pattern; DATA_OE=1 while in CYC_WAIT/CYC_TERM and R_W=1.
- Write cycles: DATA_IN is compared with expected data on the clock termination asserts; inequality sets MISMATCH until RST. In TERM_MODE 2 only DATA_IN[31:16] is compared.
- AS_n rising before termination (aborted cycle): return to CYC_IDLE with no increment.
- Peripheral side, on the SCLK edge:
  - DREQ_n=0 when DMA_GO=1, DONE=0 and no strobe is active.
  - DREQ_n returns to 1 on the first clock with DACK_n=0 and (IOR_n=0 or IOW_n=0).
  - On each DREQ_n 0->1 transition: XFER_CNT+1 and PD_OUT+1 (8-bit wrap).
  - DONE=1 when XFER_LEN≠0 and XFER_CNT==XFER_LEN. DONE clears only by RST.
  - DMA_GO falling leaves any pending request to complete.
- DREQ_n high-time between requests is at least 1 clock.

Optional Feature:
BERR_INJECT_EN: adds parameter BERR_CYCLE (default 8) and output BERR_n (reset 1).
- On the cycle where CYC_CNT==BERR_CYCLE, BERR_n asserts instead of STERM_n/DSACK_n and holds until AS_n=1.
- CYC_CNT still increments; the address and data patterns do not advance.
- Without the macro, BERR_n does not exist and no cycle is errored.

Test Plan:
- Reset mid-grant: RST during ARB_GRANT -> BG_n=1 the next clock, all outputs at reset values.
- BR_n=0, then BGACK_n=0, TERM_MODE=0, WAIT_STATES=4, master read at 32'h08000000 -> STERM_n low for 1 clock, 4 clocks after AS_n falls; DATA_OUT=32'h00000000 on cycle 0 and 32'h11000000 on cycle 1; CYC_CNT=2.
- Master writes of 32'h00000000 then 32'h11000001 -> MISMATCH=0 after the first write, 1 after the second, and still 1 after further matching writes.
- TERM_MODE=2 write -> DSACK_n=2'b01 held until AS_n high; only DATA_IN[31:16] checked.
- DMA_GO=1, XFER_LEN=3, DACK_n/IOR_n pulsed per request -> PD_OUT sequence AA, AB, AC, DREQ_n stays 1 after the third transfer, XFER_CNT=3, DONE=1.
- BERR_INJECT_EN, BERR_CYCLE=2 -> third cycle gets BERR_n=0 and no STERM_n; the fourth cycle repeats the third cycle's data.

Source files
------------

// File: rtl/dma_target_emulator_if.sv
// Bus-target and peripheral signal bundle for dma_target_emulator.
// BERR_n exists only when BERR_INJECT_EN is defined.
interface dma_target_emulator_if #(
  parameter int unsigned MAX_XFER_W = 16
);
  logic                  AS_n;
  logic                  DS_n;
  logic                  R_W;
  logic [31:0]           DATA_IN;
  logic [31:0]           DATA_OUT;
  logic                  DATA_OE;
  logic                  STERM_n;
  logic [1:0]            DSACK_n;
  logic                  BR_n;
  logic                  BGACK_n;
  logic                  BG_n;
  logic                  DMA_GO;
  logic [MAX_XFER_W-1:0] XFER_LEN;
  logic                  DACK_n;
  logic                  IOR_n;
  logic                  IOW_n;
  logic                  DREQ_n;
  logic [7:0]            PD_OUT;
  logic                  PD_OE;
  logic [MAX_XFER_W-1:0] XFER_CNT;
  logic [15:0]           CYC_CNT;
  logic                  MISMATCH;
  logic                  DONE;
`ifdef BERR_INJECT_EN
  logic                  BERR_n;
`endif

  modport master (
    output AS_n, DS_n, R_W, DATA_IN, BR_n, BGACK_n,
    output DMA_GO, XFER_LEN, DACK_n, IOR_n, IOW_n,
    input  DATA_OUT, DATA_OE, STERM_n, DSACK_n, BG_n,
    input  DREQ_n, PD_OUT, PD_OE, XFER_CNT, CYC_CNT, MISMATCH, DONE
`ifdef BERR_INJECT_EN
    , input BERR_n
`endif
  );

  modport slave (
    input  AS_n, DS_n, R_W, DATA_IN, BR_n, BGACK_n,
    input  DMA_GO, XFER_LEN, DACK_n, IOR_n, IOW_n,
    output DATA_OUT, DATA_OE, STERM_n, DSACK_n, BG_n,
    output DREQ_n, PD_OUT, PD_OE, XFER_CNT, CYC_CNT, MISMATCH, DONE
`ifdef BERR_INJECT_EN
    , output BERR_n
`endif
  );
endinterface

// File: rtl/dma_target_emulator.sv
// Bus-target / WD33C93A-side peripheral emulator for SDMAC DMA verification.
// Optional bus-error injection on cycle BERR_CYCLE is enabled by defining BERR_INJECT_EN.
module dma_target_emulator #(
  parameter int unsigned WAIT_STATES = 4,
  parameter int unsigned TERM_MODE   = 0,
  parameter int unsigned ADDR_STEP   = 4,
  parameter logic [31:0] DATA_STEP   = 32'h11000000,
  parameter logic [7:0]  PD_SEED     = 8'hAA,
  parameter int unsigned MAX_XFER_W  = 16
`ifdef BERR_INJECT_EN
  , parameter int unsigned BERR_CYCLE = 8
`endif
) (
  input logic                  SCLK,
  input logic                  RST,
  dma_target_emulator_if.slave bus
);

  localparam logic [1:0] ARB_IDLE  = 2'd0;
  localparam logic [1:0] ARB_GRANT = 2'd1;
  localparam logic [1:0] ARB_OWNED = 2'd2;

  localparam logic [1:0] CYC_IDLE = 2'd0;
  localparam logic [1:0] CYC_WAIT = 2'd1;
  localparam logic [1:0] CYC_TERM = 2'd2;
  localparam logic [1:0] CYC_END  = 2'd3;

  localparam logic [3:0]  WAIT_LOAD = 4'(WAIT_STATES - 1);
  localparam logic [31:0] CMP_MASK  = (TERM_MODE == 2) ? 32'hFFFF0000 : 32'hFFFFFFFF;

  logic [1:0]            arb_q, arb_d;
  logic                  bg_n_q, bg_n_d;
  logic [1:0]            cyc_q, cyc_d;
  logic [3:0]            wait_q, wait_d;
  logic                  sterm_n_q, sterm_n_d;
  logic [1:0]            dsack_n_q, dsack_n_d;
  logic                  err_q, err_d;
  logic                  berr_hit;
  logic [31:0]           addr_q, addr_d;
  logic [31:0]           data_q, data_d;
  logic [15:0]           cyc_cnt_q, cyc_cnt_d;
  logic                  mism_q, mism_d;
  logic                  dreq_n_q, dreq_n_d;
  logic [7:0]            pd_q, pd_d;
  logic [MAX_XFER_W-1:0] xfer_cnt_q, xfer_cnt_d;
  logic                  done_q, done_d;
  logic                  strobe;
`ifdef BERR_INJECT_EN
  logic                  berr_n_q, berr_n_d;
`endif

  // Arbiter: grant only while the bus is idle (no address strobe, no owner).
  always_comb begin
    arb_d = arb_q;
    case (arb_q)
      ARB_IDLE:  if (!bus.BR_n && bus.BGACK_n && bus.AS_n) arb_d = ARB_GRANT;
      ARB_GRANT: if (!bus.BGACK_n) arb_d = ARB_OWNED;
      ARB_OWNED: if (bus.BGACK_n) arb_d = ARB_IDLE;
      default:   arb_d = ARB_IDLE;
    endcase
    bg_n_d = (arb_d != ARB_GRANT);
  end

`ifdef BERR_INJECT_EN
  assign berr_hit = (cyc_cnt_q == 16'(BERR_CYCLE));
`else
  assign berr_hit = 1'b0;
`endif

  always_comb begin
    cyc_d     = cyc_q;
    wait_d    = wait_q;
    sterm_n_d = 1'b1;
    dsack_n_d = dsack_n_q;
    err_d     = err_q;
    addr_d    = addr_q;
    data_d    = data_q;
    cyc_cnt_d = cyc_cnt_q;
    mism_d    = mism_q;
`ifdef BERR_INJECT_EN
    berr_n_d  = berr_n_q;
`endif
    if (arb_q != ARB_OWNED) begin
      cyc_d     = CYC_IDLE;
      dsack_n_d = 2'b11;
      err_d     = 1'b0;
`ifdef BERR_INJECT_EN
      berr_n_d  = 1'b1;
`endif
    end else begin
      case (cyc_q)
        CYC_IDLE: begin
          if (!bus.AS_n) begin
            cyc_d  = CYC_WAIT;
            wait_d = WAIT_LOAD;
          end
        end
        CYC_WAIT: begin
          if (bus.AS_n) begin
            cyc_d = CYC_IDLE;
          end else if (wait_q == '0) begin
            cyc_d = CYC_TERM;
            if (berr_hit) begin
              // Errored cycle: BERR_n replaces the normal termination and skips the data check.
              err_d = 1'b1;
`ifdef BERR_INJECT_EN
              berr_n_d = 1'b0;
`endif
            end else begin
              if (TERM_MODE == 0)      sterm_n_d = 1'b0;
              else if (TERM_MODE == 1) dsack_n_d = 2'b00;
              else                     dsack_n_d = 2'b01;
              if (!bus.R_W && (((bus.DATA_IN ^ data_q) & CMP_MASK) != '0)) mism_d = 1'b1;
            end
          end else begin
            wait_d = wait_q - 4'd1;
          end
        end
        CYC_TERM: begin
          if (bus.AS_n) begin
            cyc_d     = CYC_END;
            dsack_n_d = 2'b11;
`ifdef BERR_INJECT_EN
            berr_n_d  = 1'b1;
`endif
          end
        end
        CYC_END: begin
          cyc_d     = CYC_IDLE;
          cyc_cnt_d = cyc_cnt_q + 16'd1;
          err_d     = 1'b0;
          if (!err_q) begin
            addr_d = addr_q + 32'(ADDR_STEP);
            data_d = data_q + DATA_STEP;
          end
        end
        default: cyc_d = CYC_IDLE;
      endcase
    end
  end

  // Peripheral DREQ/DACK: request drops on the strobe edge, re-arms only once strobes are idle.
  assign strobe = !bus.IOR_n || !bus.IOW_n;

  always_comb begin
    dreq_n_d   = dreq_n_q;
    pd_d       = pd_q;
    xfer_cnt_d = xfer_cnt_q;
    if (!dreq_n_q) begin
      if (!bus.DACK_n && strobe) begin
        dreq_n_d   = 1'b1;
        pd_d       = pd_q + 8'd1;
        xfer_cnt_d = xfer_cnt_q + 1'b1;
      end
    end else if (bus.DMA_GO && !done_q && !strobe) begin
      dreq_n_d = 1'b0;
    end
    done_d = done_q || ((bus.XFER_LEN != '0) && (xfer_cnt_d == bus.XFER_LEN));
  end

  always_ff @(posedge SCLK) begin
    if (RST) begin
      arb_q      <= ARB_IDLE;
      bg_n_q     <= 1'b1;
      cyc_q      <= CYC_IDLE;
      wait_q     <= '0;
      sterm_n_q  <= 1'b1;
      dsack_n_q  <= 2'b11;
      err_q      <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      cyc_cnt_q  <= '0;
      mism_q     <= 1'b0;
      dreq_n_q   <= 1'b1;
      pd_q       <= PD_SEED;
      xfer_cnt_q <= '0;
      done_q     <= 1'b0;
`ifdef BERR_INJECT_EN
      berr_n_q   <= 1'b1;
`endif
    end else begin
      arb_q      <= arb_d;
      bg_n_q     <= bg_n_d;
      cyc_q      <= cyc_d;
      wait_q     <= wait_d;
      sterm_n_q  <= sterm_n_d;
      dsack_n_q  <= dsack_n_d;
      err_q      <= err_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      cyc_cnt_q  <= cyc_cnt_d;
      mism_q     <= mism_d;
      dreq_n_q   <= dreq_n_d;
      pd_q       <= pd_d;
      xfer_cnt_q <= xfer_cnt_d;
      done_q     <= done_d;
`ifdef BERR_INJECT_EN
      berr_n_q   <= berr_n_d;
`endif
    end
  end

  assign bus.BG_n     = bg_n_q;
  assign bus.STERM_n  = sterm_n_q;
  assign bus.DSACK_n  = dsack_n_q;
  assign bus.DATA_OUT = data_q;
  assign bus.DATA_OE  = bus.R_W && ((cyc_q == CYC_WAIT) || (cyc_q == CYC_TERM));
  assign bus.CYC_CNT  = cyc_cnt_q;
  assign bus.MISMATCH = mism_q;
  assign bus.DREQ_n   = dreq_n_q;
  assign bus.PD_OUT   = pd_q;
  assign bus.PD_OE    = ~bus.IOR_n;
  assign bus.XFER_CNT = xfer_cnt_q;
  assign bus.DONE     = done_q;
`ifdef BERR_INJECT_EN
  assign bus.BERR_n   = berr_n_q;
`endif

  // The address pattern has no output pin; DS_n is not needed to terminate cycles.
  logic unused_sinks;
  assign unused_sinks = ^{bus.DS_n, addr_q};

endmodule
